// File: rtl/ahb_fabric_slave.sv
// ahb_fabric_slave: AHB-Lite responder with CTRL/STATUS/SCRATCH/LEVEL/IRQ_STAT registers and a TXDATA FIFO.
// Define AHB_SLV_BYTE_LANES_EN to allow byte/halfword writes to CTRL and SCRATCH.
module ahb_fabric_slave #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WAIT_MAX   = 15
) (
    input  logic        SYSCLK,
    input  logic        NSYSRESET,
    input  logic        HSEL,
    input  logic [4:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in,
    output logic [31:0] fifo_data,
    output logic        fifo_valid,
    input  logic        fifo_ready,
    output logic        fab_int
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_SCRATCH = 3'd2;
    localparam logic [2:0] REG_TXDATA  = 3'd3;
    localparam logic [2:0] REG_LEVEL   = 3'd4;
    localparam logic [2:0] REG_IRQ     = 3'd5;

    typedef enum logic [2:0] {IDLE, DATA, WFULL, ERR1, ERR2} state_t;

    state_t        state;
    logic [2:0]    dp_idx;
    logic          dp_write;
`ifdef AHB_SLV_BYTE_LANES_EN
    logic [1:0]    dp_lsb;
    logic [2:0]    dp_size;
`endif
    logic [31:0]   ctrl;
    logic [31:0]   scratch;
    logic [1:0]    irq;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;

    logic          accept;
    logic [2:0]    a_idx;
    logic          size_err;
    logic          addr_err;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          space;
    logic          timeout;
    logic [3:0]    wstrb;
    logic [CW-1:0] count_nxt;
    logic [31:0]   ctrl_nxt;
    logic [31:0]   scratch_nxt;
    logic [1:0]    irq_nxt;
    logic [31:0]   rd_word;
    logic          unused_inputs;

    assign unused_inputs = ^{HTRANS[0], HADDR[1:0]};
    assign ctrl_out      = ctrl;
    assign fifo_data     = mem[rd_ptr];

    // Address-phase decode and legality check
    always_comb begin
        accept = HSEL & HTRANS[1] & HREADYOUT;
        a_idx  = HADDR[4:2];
`ifdef AHB_SLV_BYTE_LANES_EN
        size_err = (HSIZE > 3'd2) |
                   (HWRITE & (HSIZE != 3'd2) & ((a_idx == REG_TXDATA) | (a_idx == REG_IRQ)));
`else
        size_err = (HSIZE != 3'd2);
`endif
        addr_err = (a_idx[2] & a_idx[1]) | size_err;
    end

    // Byte-lane strobes for the write in the data phase
    always_comb begin
        wstrb = 4'b1111;
`ifdef AHB_SLV_BYTE_LANES_EN
        case (dp_size)
            3'd0:    wstrb = 4'b0001 << dp_lsb;
            3'd1:    wstrb = dp_lsb[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
`endif
    end

    // Next register values; reads forward these so a read right after a write sees new data
    always_comb begin
        wr_en       = (state == DATA) & dp_write;
        push        = wr_en & (dp_idx == REG_TXDATA);
        pop         = fifo_valid & fifo_ready;
        count_nxt   = count + CW'(push) - CW'(pop);
        space       = (count_nxt != CW'(FIFO_DEPTH));
        timeout     = (state == WFULL) & ~space & (wait_cnt == WW'(WAIT_MAX - 1));
        ctrl_nxt    = ctrl;
        scratch_nxt = scratch;
        for (int i = 0; i < 4; i++) begin
            if (wr_en && dp_idx == REG_CTRL && wstrb[i])
                ctrl_nxt[8*i +: 8] = HWDATA[8*i +: 8];
            if (wr_en && dp_idx == REG_SCRATCH && wstrb[i])
                scratch_nxt[8*i +: 8] = HWDATA[8*i +: 8];
        end
        irq_nxt = irq;
        if (wr_en && dp_idx == REG_IRQ)
            irq_nxt = irq & ~HWDATA[1:0];
        if (pop && !push && count == CW'(1))
            irq_nxt[0] = 1'b1;
        if (timeout)
            irq_nxt[1] = 1'b1;
        case (a_idx)
            REG_CTRL:    rd_word = ctrl_nxt;
            REG_STATUS:  rd_word = status_in;
            REG_SCRATCH: rd_word = scratch_nxt;
            REG_LEVEL:   rd_word = 32'(count_nxt);
            REG_IRQ:     rd_word = {30'd0, irq_nxt};
            default:     rd_word = 32'd0;
        endcase
    end

    // Bus FSM, registers and FIFO pointers
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state      <= IDLE;
            HREADYOUT  <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= 32'd0;
            dp_idx     <= 3'd0;
            dp_write   <= 1'b0;
`ifdef AHB_SLV_BYTE_LANES_EN
            dp_lsb     <= 2'd0;
            dp_size    <= 3'd0;
`endif
            ctrl       <= 32'd0;
            scratch    <= 32'd0;
            irq        <= 2'd0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wait_cnt   <= '0;
            fifo_valid <= 1'b0;
            fab_int    <= 1'b0;
        end else begin
            ctrl       <= ctrl_nxt;
            scratch    <= scratch_nxt;
            irq        <= irq_nxt;
            count      <= count_nxt;
            fifo_valid <= (count_nxt != '0);
            fab_int    <= |(irq_nxt & ctrl_nxt[1:0]);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            HRDATA <= 32'd0;
            case (state)
                IDLE, DATA, ERR2: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept) begin
                        dp_idx   <= a_idx;
                        dp_write <= HWRITE;
`ifdef AHB_SLV_BYTE_LANES_EN
                        dp_lsb   <= HADDR[1:0];
                        dp_size  <= HSIZE;
`endif
                        if (addr_err) begin
                            state     <= ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (HWRITE && a_idx == REG_TXDATA && !space) begin
                            state     <= WFULL;
                            HREADYOUT <= 1'b0;
                            wait_cnt  <= '0;
                        end else begin
                            state <= DATA;
                            if (!HWRITE) HRDATA <= rd_word;
                        end
                    end
                end
                WFULL: begin
                    if (space) begin
                        // A pop this cycle frees a slot; the push happens in the DATA cycle
                        state     <= DATA;
                        HREADYOUT <= 1'b1;
                    end else if (timeout) begin
                        state <= ERR1;
                        HRESP <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                ERR1: begin
                    state     <= ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge SYSCLK) begin
        if (push) mem[wr_ptr] <= HWDATA;
    end
endmodule
